// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the boot-time system-ID checker.
// The enum encoding is fixed so the debug state output stays stable across builds.
package sysid_checker_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ID_SETTLE = 3'd1,
      ID_SAMPLE = 3'd2,
      TS_SETTLE = 3'd3,
      TS_SAMPLE = 3'd4,
      DONE      = 3'd5
   } state_e;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h623B_3288;

   function automatic logic state_is_busy(input state_e s);
      return (s == ID_SETTLE) || (s == ID_SAMPLE) || (s == TS_SETTLE) || (s == TS_SAMPLE);
   endfunction

endpackage

// File: rtl/sysid_checker_word_sampler.sv
// Holds the first capture of one sysid word and flags any later capture that differs.
// The *_next outputs expose the values that will be registered at the coming edge.
module sysid_word_sampler (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        capture,
   input  logic        first,
   input  logic [31:0] data,
   output logic [31:0] value,
   output logic [31:0] value_next,
   output logic        mismatch,
   output logic        mismatch_next
);

   logic [31:0] value_q, value_d;
   logic        mismatch_q, mismatch_d;

   always_comb begin
      value_d    = value_q;
      mismatch_d = mismatch_q;
      if (clear) begin
         value_d    = '0;
         mismatch_d = 1'b0;
      end else if (capture) begin
         if (first) begin
            value_d = data;
         end else if (data != value_q) begin
            mismatch_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value_q    <= '0;
         mismatch_q <= 1'b0;
      end else begin
         value_q    <= value_d;
         mismatch_q <= mismatch_d;
      end
   end

   assign value         = value_q;
   assign value_next    = value_d;
   assign mismatch      = mismatch_q;
   assign mismatch_next = mismatch_d;

endmodule

// File: rtl/sysid_checker.sv
// Boot-time checker: walks the sysid slave address, samples ID and timestamp words,
// and reports match/stability results to the boot sequencer.
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID   = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS   = DEFAULT_EXPECTED_TS,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned SAMPLES       = 2,
   parameter bit          AUTO_START    = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        unstable,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [2:0]  dbg_state
);

   localparam int unsigned PHASE_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int          CNT_W     = $clog2(PHASE_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLES - 1);
   localparam state_e ID_FIRST = (SETTLE_CYCLES > 0) ? ID_SETTLE : ID_SAMPLE;
   localparam state_e TS_FIRST = (SETTLE_CYCLES > 0) ? TS_SETTLE : TS_SAMPLE;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             auto_q, auto_d;
   logic             id_ok_q, id_ok_d;
   logic             ts_ok_q, ts_ok_d;

   logic [31:0] id_val_next, ts_val_next;
   logic        id_mis, ts_mis, id_mis_next, ts_mis_next;

   // A start (or the post-reset auto start) is registered only while idle,
   // so requests arriving while busy or in DONE are dropped rather than queued.
   always_comb begin
      req_d   = (start | auto_q) & (state_q == IDLE);
      auto_d  = 1'b0;
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (req_q) state_d = ID_FIRST;
         ID_SETTLE: if (cnt_q == SETTLE_LAST) state_d = ID_SAMPLE;
         ID_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = TS_FIRST;
         TS_SETTLE: if (cnt_q == SETTLE_LAST) state_d = TS_SAMPLE;
         TS_SAMPLE: if (cnt_q == SAMPLE_LAST) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
   end

   sysid_word_sampler u_id_sampler (
      .clock         (clock),
      .reset_n       (reset_n),
      .clear         (req_d),
      .capture       (state_q == ID_SAMPLE),
      .first         (cnt_q == '0),
      .data          (sysid_readdata),
      .value         (id_value),
      .value_next    (id_val_next),
      .mismatch      (id_mis),
      .mismatch_next (id_mis_next)
   );

   sysid_word_sampler u_ts_sampler (
      .clock         (clock),
      .reset_n       (reset_n),
      .clear         (req_d),
      .capture       (state_q == TS_SAMPLE),
      .first         (cnt_q == '0),
      .data          (sysid_readdata),
      .value         (ts_value),
      .value_next    (ts_val_next),
      .mismatch      (ts_mis),
      .mismatch_next (ts_mis_next)
   );

   // Verdicts use the sampler next-values: the last timestamp capture lands on the DONE edge.
   always_comb begin
      id_ok_d = id_ok_q;
      ts_ok_d = ts_ok_q;
      if (req_d) begin
         id_ok_d = 1'b0;
         ts_ok_d = 1'b0;
      end else if (state_q == TS_SAMPLE && state_d == DONE) begin
         id_ok_d = (id_val_next == EXPECTED_ID) && !(id_mis_next || ts_mis_next);
         ts_ok_d = (ts_val_next == EXPECTED_TS) && !(id_mis_next || ts_mis_next);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         auto_q  <= AUTO_START;
         id_ok_q <= 1'b0;
         ts_ok_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         auto_q  <= auto_d;
         id_ok_q <= id_ok_d;
         ts_ok_q <= ts_ok_d;
      end
   end

   assign sysid_address = (state_q == TS_SETTLE || state_q == TS_SAMPLE) ? ADDR_TS : ADDR_ID;
   assign busy          = state_is_busy(state_q);
   assign done          = (state_q == DONE);
   assign id_ok         = id_ok_q;
   assign ts_ok         = ts_ok_q;
   assign unstable      = id_mis | ts_mis;
   assign dbg_state     = state_q;

endmodule
